// File: rtl/hm_display_sequencer.sv
// Display channel sequencer for the health monitor: selects one of NCH packed-BCD
// result channels for the seven-segment controller (manual, auto-scan or hold) and
// raises sticky per-channel over-threshold alarms.
module hm_display_sequencer #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SCAN_TICKS  = 3000,
  parameter int unsigned ALARM_TICKS = 500,
  parameter int unsigned CHW         = $clog2(NCH)
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic [NCH*DIGITS*4-1:0]  ch_bcd,
  input  logic [NCH-1:0]           ch_valid,
  input  logic [NCH*DIGITS*4-1:0]  ch_thresh,
  input  logic                     next_pulse,
  input  logic                     auto_en,
  input  logic                     hold_pulse,
  input  logic                     alarm_clr,
  output logic [DIGITS*4-1:0]      disp_bcd,
  output logic                     disp_blank,
  output logic [CHW-1:0]           sel_ch,
  output logic                     held,
  output logic [NCH-1:0]           alarm,
  output logic                     alarm_any
);

  localparam int unsigned DW = DIGITS * 4;
  localparam int unsigned SW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int unsigned AW = $clog2(ALARM_TICKS + 1);
  localparam logic [SW-1:0] ScanLast = SW'(SCAN_TICKS - 1);
  localparam logic [AW-1:0] AlarmMax = AW'(ALARM_TICKS);

  localparam logic [1:0] StManual = 2'd0;
  localparam logic [1:0] StAuto   = 2'd1;
  localparam logic [1:0] StHold   = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [CHW-1:0] sel_q, sel_d;
  logic [SW-1:0]  scan_q, scan_d;
  logic [DW-1:0]  disp_q, disp_d;
  logic           blank_q, blank_d;
  logic           held_q, held_d;
  logic [NCH-1:0] alarm_q, alarm_d;
  logic           alarm_any_q;
  logic           advance;

  logic [DW-1:0]  ch_word [NCH];
  logic [DW-1:0]  th_word [NCH];
  logic [NCH-1:0] over;
  logic [AW-1:0]  acnt_q [NCH];
  logic [AW-1:0]  acnt_d [NCH];

  // Next valid channel after cur, wrapping; stays on cur when no other channel is valid.
  function automatic logic [CHW-1:0] next_valid(input logic [CHW-1:0] cur,
                                                input logic [NCH-1:0] v);
    logic [CHW-1:0] res;
    logic [CHW-1:0] ci;
    logic           found;
    res   = cur;
    found = 1'b0;
    for (int unsigned s = 1; s < NCH; s++) begin
      ci = CHW'((32'(cur) + s) % NCH);
      if (!found && v[ci]) begin
        res   = ci;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Per-channel word extraction and alarm qualification counters.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign ch_word[g] = ch_bcd[g*DW +: DW];
    assign th_word[g] = ch_thresh[g*DW +: DW];
    // Packed BCD compares correctly as unsigned binary for legal digits.
    assign over[g]    = ch_valid[g] && (ch_word[g] > th_word[g]);
    assign acnt_d[g]  = (alarm_clr || !over[g]) ? '0 :
                        (acnt_q[g] < AlarmMax)  ? acnt_q[g] + 1'b1 : acnt_q[g];
    // Clear beats a coincident set.
    assign alarm_d[g] = !alarm_clr && (alarm_q[g] || (acnt_d[g] == AlarmMax));

    // Qualification counter register.
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        acnt_q[g] <= '0;
      end else begin
        acnt_q[g] <= acnt_d[g];
      end
    end
  end

  // Display mode next-state: hold toggling, manual/auto advance and live capture.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    scan_d  = scan_q;
    disp_d  = disp_q;
    blank_d = blank_q;
    advance = 1'b0;
    case (state_q)
      StHold: begin
        if (hold_pulse) begin
          state_d = auto_en ? StAuto : StManual;
          scan_d  = '0;
          disp_d  = ch_word[sel_q];
          blank_d = !ch_valid[sel_q];
        end
      end
      default: begin
        // Live path; on a hold request this same update is the snapshot.
        disp_d  = ch_word[sel_q];
        blank_d = !ch_valid[sel_q];
        if (hold_pulse) begin
          state_d = StHold;
        end else begin
          if ((state_q == StAuto) && auto_en) begin
            // A button press and a scan expiry together still advance only once.
            advance = next_pulse || (scan_q == ScanLast);
            scan_d  = advance ? '0 : scan_q + 1'b1;
          end else begin
            advance = next_pulse;
            scan_d  = '0;
          end
          state_d = auto_en ? StAuto : StManual;
          if (advance) begin
            sel_d = next_valid(sel_q, ch_valid);
          end
        end
      end
    endcase
    held_d = (state_d == StHold);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= StManual;
      sel_q       <= '0;
      scan_q      <= '0;
      disp_q      <= '0;
      blank_q     <= 1'b1;
      held_q      <= 1'b0;
      alarm_q     <= '0;
      alarm_any_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      scan_q      <= scan_d;
      disp_q      <= disp_d;
      blank_q     <= blank_d;
      held_q      <= held_d;
      alarm_q     <= alarm_d;
      alarm_any_q <= |alarm_d;
    end
  end

  assign disp_bcd   = disp_q;
  assign disp_blank = blank_q;
  assign sel_ch     = sel_q;
  assign held       = held_q;
  assign alarm      = alarm_q;
  assign alarm_any  = alarm_any_q;

endmodule

// File: tb/tb_hm_display_sequencer.sv
// Self-checking bench for hm_display_sequencer: directed vectors, a behavioural
// reference model compared every cycle, plus literal expectations at key points.
module tb_hm_display_sequencer;

  localparam int NCH  = 4;
  localparam int DIG  = 4;
  localparam int SCAN = 3000;
  localparam int AT   = 500;
  localparam int CHW  = 2;
  localparam int DW   = 16;

  localparam int MMan  = 0;
  localparam int MAuto = 1;
  localparam int MHold = 2;

  logic                  clk = 1'b0;
  logic                  rst_l = 1'b0;
  logic [NCH*DW-1:0]     ch_bcd;
  logic [NCH-1:0]        ch_valid;
  logic [NCH*DW-1:0]     ch_thresh;
  logic                  next_pulse;
  logic                  auto_en;
  logic                  hold_pulse;
  logic                  alarm_clr;
  logic [DW-1:0]         disp_bcd;
  logic                  disp_blank;
  logic [CHW-1:0]        sel_ch;
  logic                  held;
  logic [NCH-1:0]        alarm;
  logic                  alarm_any;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  hm_display_sequencer #(
    .NCH        (NCH),
    .DIGITS     (DIG),
    .SCAN_TICKS (SCAN),
    .ALARM_TICKS(AT),
    .CHW        (CHW)
  ) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .ch_bcd    (ch_bcd),
    .ch_valid  (ch_valid),
    .ch_thresh (ch_thresh),
    .next_pulse(next_pulse),
    .auto_en   (auto_en),
    .hold_pulse(hold_pulse),
    .alarm_clr (alarm_clr),
    .disp_bcd  (disp_bcd),
    .disp_blank(disp_blank),
    .sel_ch    (sel_ch),
    .held      (held),
    .alarm     (alarm),
    .alarm_any (alarm_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nv(input int cur, input logic [NCH-1:0] v);
    int c;
    for (int s = 1; s < NCH; s++) begin
      c = (cur + s) % NCH;
      if (v[c[CHW-1:0]]) return c;
    end
    return cur;
  endfunction

  function automatic logic [DW-1:0] word_at(input logic [NCH*DW-1:0] bus, input int k);
    return DW'(bus >> (k * DW));
  endfunction

  function automatic logic valid_at(input logic [NCH-1:0] v, input int k);
    return v[k[CHW-1:0]];
  endfunction

  int            m_mode, m_sel, m_scan;
  logic [DW-1:0] m_disp;
  logic          m_blank;
  int            m_acnt [NCH];
  logic [NCH-1:0] m_alarm;

  int            e_mode, e_sel, e_scan;
  logic [DW-1:0] e_disp;
  logic          e_blank;
  int            e_acnt [NCH];
  logic [NCH-1:0] e_alarm;
  logic          e_adv;

  always_comb begin
    e_mode  = m_mode;
    e_sel   = m_sel;
    e_scan  = m_scan;
    e_disp  = m_disp;
    e_blank = m_blank;
    e_adv   = 1'b0;
    if (m_mode == MHold) begin
      if (hold_pulse) begin
        e_mode  = auto_en ? MAuto : MMan;
        e_scan  = 0;
        e_disp  = word_at(ch_bcd, m_sel);
        e_blank = !valid_at(ch_valid, m_sel);
      end
    end else begin
      e_disp  = word_at(ch_bcd, m_sel);
      e_blank = !valid_at(ch_valid, m_sel);
      if (hold_pulse) begin
        e_mode = MHold;
      end else begin
        if (m_mode == MAuto && auto_en) begin
          if (next_pulse || m_scan == SCAN - 1) begin
            e_adv  = 1'b1;
            e_scan = 0;
          end else begin
            e_scan = m_scan + 1;
          end
        end else begin
          e_adv  = next_pulse;
          e_scan = 0;
        end
        e_mode = auto_en ? MAuto : MMan;
        if (e_adv) e_sel = nv(m_sel, ch_valid);
      end
    end
    e_acnt  = m_acnt;
    e_alarm = m_alarm;
    for (int k = 0; k < NCH; k++) begin
      if (alarm_clr) begin
        e_acnt[k] = 0;
        e_alarm[k] = 1'b0;
      end else if (valid_at(ch_valid, k) && word_at(ch_bcd, k) > word_at(ch_thresh, k)) begin
        if (m_acnt[k] < AT) e_acnt[k] = m_acnt[k] + 1;
        if (e_acnt[k] == AT) e_alarm[k] = 1'b1;
      end else begin
        e_acnt[k] = 0;
      end
    end
  end

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_mode  <= MMan;
      m_sel   <= 0;
      m_scan  <= 0;
      m_disp  <= '0;
      m_blank <= 1'b1;
      m_alarm <= '0;
      for (int k = 0; k < NCH; k++) m_acnt[k] <= 0;
    end else begin
      m_mode  <= e_mode;
      m_sel   <= e_sel;
      m_scan  <= e_scan;
      m_disp  <= e_disp;
      m_blank <= e_blank;
      m_alarm <= e_alarm;
      m_acnt  <= e_acnt;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model sel_ch", 64'(sel_ch), 64'(m_sel[CHW-1:0]));
      check("model disp_bcd", 64'(disp_bcd), 64'(m_disp));
      check("model disp_blank", 64'(disp_blank), 64'(m_blank));
      check("model held", 64'(held), 64'(m_mode == MHold));
      check("model alarm", 64'(alarm), 64'(m_alarm));
      check("model alarm_any", 64'(alarm_any), 64'(|m_alarm));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse_next();
    next_pulse = 1'b1;
    cyc();
    next_pulse = 1'b0;
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] v);
    ch_bcd[k*DW +: DW] = v;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " sel_ch"}, 64'(sel_ch), 64'(0));
    check({tag, " disp_bcd"}, 64'(disp_bcd), 64'(0));
    check({tag, " disp_blank"}, 64'(disp_blank), 64'(1));
    check({tag, " held"}, 64'(held), 64'(0));
    check({tag, " alarm"}, 64'(alarm), 64'(0));
    check({tag, " alarm_any"}, 64'(alarm_any), 64'(0));
  endtask

  initial begin
    int exp_sel;
    logic [3:0] dg;
    ch_valid   = '1;
    ch_thresh  = {NCH{16'h9999}};
    next_pulse = 1'b0;
    auto_en    = 1'b0;
    hold_pulse = 1'b0;
    alarm_clr  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      dg = 4'(k + 1);
      set_ch(k, {4{dg}});
    end

    cyc();
    cmp_en = 1'b1;
    check_reset_vals("reset");
    cyc();
    rst_l = 1'b1;
    cyc();

    // Manual advance skipping invalid channels.
    ch_valid = 4'b1001;
    pulse_next();
    check("skip to ch3", 64'(sel_ch), 64'(3));
    pulse_next();
    check("wrap to ch0", 64'(sel_ch), 64'(0));
    cyc();
    check("ch0 shown", 64'(disp_bcd), 64'(16'h1111));
    ch_valid = 4'b0000;
    pulse_next();
    check("none valid sel", 64'(sel_ch), 64'(0));
    cyc();
    check("none valid blank", 64'(disp_blank), 64'(1));
    ch_valid = '1;
    cyc();

    // Hold freezes the snapshot.
    pulse_next();
    check("manual to ch1", 64'(sel_ch), 64'(1));
    set_ch(1, 16'h0072);
    cyc();
    check("live 0072", 64'(disp_bcd), 64'(16'h0072));
    hold_pulse = 1'b1;
    cyc();
    hold_pulse = 1'b0;
    check("hold entered", 64'(held), 64'(1));
    set_ch(1, 16'h0088);
    next_pulse = 1'b1;
    auto_en    = 1'b1;
    cyc();
    next_pulse = 1'b0;
    cycles(3);
    check("hold disp frozen", 64'(disp_bcd), 64'(16'h0072));
    check("hold sel frozen", 64'(sel_ch), 64'(1));
    check("hold held", 64'(held), 64'(1));
    auto_en    = 1'b0;
    hold_pulse = 1'b1;
    cyc();
    hold_pulse = 1'b0;
    check("hold released", 64'(held), 64'(0));
    check("live 0088", 64'(disp_bcd), 64'(16'h0088));

    // Hold and next in the same cycle: hold wins, capture pre-advance channel.
    set_ch(1, 16'h2222);
    cyc();
    hold_pulse = 1'b1;
    next_pulse = 1'b1;
    cyc();
    hold_pulse = 1'b0;
    next_pulse = 1'b0;
    check("coincident held", 64'(held), 64'(1));
    check("coincident sel", 64'(sel_ch), 64'(1));
    check("coincident disp", 64'(disp_bcd), 64'(16'h2222));
    cycles(2);
    hold_pulse = 1'b1;
    cyc();
    hold_pulse = 1'b0;
    check("coincident exit", 64'(held), 64'(0));

    // Alarm qualification, stickiness and clear.
    ch_thresh[15:0] = 16'h0100;
    set_ch(0, 16'h0101);
    cycles(499);
    set_ch(0, 16'h0099);
    cycles(2);
    check("499 no alarm", 64'(alarm), 64'(0));
    check("499 no any", 64'(alarm_any), 64'(0));
    set_ch(0, 16'h0101);
    cycles(499);
    check("alarm not yet", 64'(alarm), 64'(0));
    cyc();
    check("alarm at 500", 64'(alarm), 64'(4'b0001));
    check("alarm_any set", 64'(alarm_any), 64'(1));
    set_ch(0, 16'h0099);
    cycles(5);
    check("alarm sticky", 64'(alarm), 64'(4'b0001));
    alarm_clr = 1'b1;
    cyc();
    alarm_clr = 1'b0;
    check("alarm cleared", 64'(alarm), 64'(0));
    check("alarm_any cleared", 64'(alarm_any), 64'(0));
    set_ch(0, 16'h0101);
    cycles(499);
    alarm_clr = 1'b1;
    cyc();
    alarm_clr = 1'b0;
    check("clear beats set", 64'(alarm), 64'(0));
    cycles(499);
    check("rearm not yet", 64'(alarm), 64'(0));
    cyc();
    check("rearm after 500", 64'(alarm), 64'(4'b0001));
    set_ch(0, 16'h1111);
    ch_thresh[15:0] = 16'h9999;
    alarm_clr = 1'b1;
    cyc();
    alarm_clr = 1'b0;
    check("final clear", 64'(alarm_any), 64'(0));

    // Auto-scan rotation at exact intervals.
    pulse_next();
    pulse_next();
    pulse_next();
    check("back to ch0", 64'(sel_ch), 64'(0));
    auto_en = 1'b1;
    cyc();
    exp_sel = 0;
    for (int i = 0; i < NCH; i++) begin
      cyc();
      dg = 4'(exp_sel + 1);
      check("auto disp", 64'(disp_bcd), 64'({4{dg}}));
      cycles(2998);
      check("auto dwell", 64'(sel_ch), 64'(exp_sel));
      cyc();
      exp_sel = (exp_sel + 1) % NCH;
      check("auto step", 64'(sel_ch), 64'(exp_sel));
    end

    // Asynchronous reset in the middle of an auto-scan dwell.
    cycles(2 * SCAN + SCAN / 2);
    check("mid auto sel", 64'(sel_ch), 64'(2));
    #2;
    rst_l = 1'b0;
    #1;
    check_reset_vals("async reset");
    auto_en = 1'b0;
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    cyc();
    check("post reset sel", 64'(sel_ch), 64'(0));
    check("post reset held", 64'(held), 64'(0));
    pulse_next();
    check("post reset manual", 64'(sel_ch), 64'(1));
    cycles(2);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
